// File: rtl/decode_pkg.sv
// Shared encodings for the RV32I(+M) decode stage: opcodes, ALU ops, write-back/load-store
// selects, funct3 groups and the packed control bundle passed from decoder to pipeline register.
package decode_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLT    = 5'd2,
        ALU_SLTU   = 5'd3,
        ALU_AND    = 5'd4,
        ALU_OR     = 5'd5,
        ALU_XOR    = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_e;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [3:0] SL_BYTE = 4'b0001;
    localparam logic [3:0] SL_HALF = 4'b0011;
    localparam logic [3:0] SL_WORD = 4'b1111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_f3_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_f3_e;

    typedef struct packed {
        logic       is_pc;
        logic       br_unsigned;
        logic       rd_wren;
        logic       op_a_sel;
        logic       op_b_sel;
        logic       mem_wren;
        logic       ls_unsign;
        logic [4:0] alu_op;
        logic [1:0] wb_sel;
        logic [3:0] sl_op;
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rd_addr;
    } ctrl_t;

    // Base integer ALU op for OP / OP-IMM; alt selects SUB/SRA (funct7 = 0100000).
    function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational RV32I decoder: instruction word to control bundle, immediate and operand-use flags.
// Define RV32M_EN to decode the M-extension (MUL..REMU); otherwise those encodings are illegal.
module instr_decode import decode_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic            illegal
);

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_sh = {27'b0, instr[24:20]};

    ctrl_t       c;
    logic [31:0] imm32;
    logic        u1, u2, bad;

    always_comb begin
        c             = '0;
        c.br_unsigned = 1'b1;
        c.ls_unsign   = 1'b1;
        c.rs1_addr    = instr[19:15];
        c.rs2_addr    = instr[24:20];
        c.rd_addr     = instr[11:7];
        imm32         = '0;
        u1            = 1'b1;
        u2            = 1'b0;
        bad           = 1'b0;

        case (instr[6:0])
            OPC_LUI: begin
                c.rd_wren  = 1'b1;
                c.op_b_sel = 1'b1;
                c.wb_sel   = WB_ALU;
                imm32      = imm_u;
                u1         = 1'b0;
            end
            OPC_AUIPC: begin
                c.rd_wren  = 1'b1;
                c.op_a_sel = 1'b1;
                c.op_b_sel = 1'b1;
                c.wb_sel   = WB_ALU;
                imm32      = imm_u;
                u1         = 1'b0;
            end
            OPC_JAL: begin
                c.is_pc    = 1'b1;
                c.rd_wren  = 1'b1;
                c.op_a_sel = 1'b1;
                c.op_b_sel = 1'b1;
                c.wb_sel   = WB_PC4;
                imm32      = imm_j;
                u1         = 1'b0;
            end
            OPC_JALR: begin
                c.is_pc    = 1'b1;
                c.rd_wren  = 1'b1;
                c.op_b_sel = 1'b1;
                c.wb_sel   = WB_PC4;
                imm32      = imm_i;
                bad        = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                c.is_pc    = 1'b1;
                c.op_a_sel = 1'b1;
                c.op_b_sel = 1'b1;
                imm32      = imm_b;
                u2         = 1'b1;
                case (f3)
                    F3_BEQ, F3_BNE, F3_BLT, F3_BGE: c.br_unsigned = 1'b0;
                    F3_BLTU, F3_BGEU:               c.br_unsigned = 1'b1;
                    default:                        bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                c.rd_wren   = 1'b1;
                c.op_b_sel  = 1'b1;
                c.wb_sel    = WB_MEM;
                c.ls_unsign = 1'b0;
                imm32       = imm_i;
                case (f3)
                    F3_LB:   c.sl_op = SL_BYTE;
                    F3_LH:   c.sl_op = SL_HALF;
                    F3_LW:   c.sl_op = SL_WORD;
                    F3_LBU: begin
                        c.sl_op     = SL_BYTE;
                        c.ls_unsign = 1'b1;
                    end
                    F3_LHU: begin
                        c.sl_op     = SL_HALF;
                        c.ls_unsign = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                c.mem_wren  = 1'b1;
                c.op_b_sel  = 1'b1;
                c.ls_unsign = 1'b0;
                imm32       = imm_s;
                u2          = 1'b1;
                case (f3)
                    F3_SB:   c.sl_op = SL_BYTE;
                    F3_SH:   c.sl_op = SL_HALF;
                    F3_SW:   c.sl_op = SL_WORD;
                    default: bad = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                c.rd_wren  = 1'b1;
                c.op_b_sel = 1'b1;
                c.wb_sel   = WB_ALU;
                c.alu_op   = alu_from_f3(f3, f7 == F7_ALT);
                imm32      = imm_i;
                // Shift amounts are unsigned; funct7 lives in the upper immediate bits.
                if (f3 == 3'b001) begin
                    imm32 = imm_sh;
                    bad   = (f7 != F7_BASE);
                end else if (f3 == 3'b101) begin
                    imm32 = imm_sh;
                    bad   = (f7 != F7_BASE) && (f7 != F7_ALT);
                end
            end
            OPC_OP: begin
                c.rd_wren = 1'b1;
                c.wb_sel  = WB_ALU;
                u2        = 1'b1;
                if (f7 == F7_BASE) begin
                    c.alu_op = alu_from_f3(f3, 1'b0);
                end else if ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
                    c.alu_op = alu_from_f3(f3, 1'b1);
`ifdef RV32M_EN
                end else if (f7 == F7_MULDIV) begin
                    c.alu_op = 5'(ALU_MUL) + 5'(f3);
`endif
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase

        // Illegal words travel downstream as a harmless NOP carrying only the flag.
        if (bad) begin
            c     = '0;
            imm32 = '0;
            u1    = 1'b0;
            u2    = 1'b0;
        end
    end

    assign ctrl     = c;
    assign imm      = XLEN'($signed(imm32));
    assign uses_rs1 = u1;
    assign uses_rs2 = u2;
    assign illegal  = bad;

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decoder, ID/EX register, load-use interlock, flush, stall counter.
// RV32M_EN (see instr_decode) enables M-extension decode.
module decode_stage import decode_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  pc_o,
    output logic             is_pc_o,
    output logic             br_unsigned_o,
    output logic             rd_wren_o,
    output logic             op_a_sel_o,
    output logic             op_b_sel_o,
    output logic             mem_wren_o,
    output logic             ls_unsign_o,
    output logic [4:0]       alu_op_o,
    output logic [1:0]       wb_sel_o,
    output logic [3:0]       sl_op_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [4:0]       rs1_addr_o,
    output logic [4:0]       rs2_addr_o,
    output logic [4:0]       rd_addr_o,
    output logic             illegal_o,
    output logic             hazard_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic            dec_uses_rs1, dec_uses_rs2, dec_illegal;

    instr_decode #(.XLEN(XLEN)) u_instr_decode (
        .instr    (instr_i),
        .ctrl     (dec_ctrl),
        .imm      (dec_imm),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .illegal  (dec_illegal)
    );

    ctrl_t            ctrl_q;
    logic [XLEN-1:0]  imm_q, pc_q;
    logic             valid_q, illegal_q;
    logic [CNT_W-1:0] cnt_q;

    logic held_load, rs1_hit, rs2_hit, hazard, ready, xfer_in, xfer_out;

    // A held load's result is not ready for the next instruction: hold it back one cycle.
    assign held_load = valid_q && ctrl_q.rd_wren && (ctrl_q.wb_sel == WB_MEM)
                    && (ctrl_q.rd_addr != 5'd0);
    assign rs1_hit   = dec_uses_rs1 && (dec_ctrl.rs1_addr == ctrl_q.rd_addr);
    assign rs2_hit   = dec_uses_rs2 && (dec_ctrl.rs2_addr == ctrl_q.rd_addr);
    assign hazard    = valid_i && held_load && (rs1_hit || rs2_hit);

    // Handshake: a word moves on a side only in a cycle where both valid and ready are high;
    // valid_o never drops and outputs never change while valid_o && !ready_i (except flush).
    assign ready    = (!valid_q || ready_i) && !hazard;
    assign xfer_in  = valid_i && ready;
    assign xfer_out = valid_q && ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            illegal_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (xfer_in) begin
            valid_q   <= 1'b1;
            ctrl_q    <= dec_ctrl;
            imm_q     <= dec_imm;
            pc_q      <= pc_i;
            illegal_q <= dec_illegal;
        end else if (xfer_out) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (hazard && !flush_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign ready_o       = ready;
    assign hazard_o      = hazard;
    assign valid_o       = valid_q;
    assign pc_o          = pc_q;
    assign is_pc_o       = ctrl_q.is_pc;
    assign br_unsigned_o = ctrl_q.br_unsigned;
    assign rd_wren_o     = ctrl_q.rd_wren;
    assign op_a_sel_o    = ctrl_q.op_a_sel;
    assign op_b_sel_o    = ctrl_q.op_b_sel;
    assign mem_wren_o    = ctrl_q.mem_wren;
    assign ls_unsign_o   = ctrl_q.ls_unsign;
    assign alu_op_o      = ctrl_q.alu_op;
    assign wb_sel_o      = ctrl_q.wb_sel;
    assign sl_op_o       = ctrl_q.sl_op;
    assign imm_o         = imm_q;
    assign rs1_addr_o    = ctrl_q.rs1_addr;
    assign rs2_addr_o    = ctrl_q.rs2_addr;
    assign rd_addr_o     = ctrl_q.rd_addr;
    assign illegal_o     = illegal_q;
    assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table, load-use bubble, backpressure, flush,
// counter saturation and asynchronous reset.
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk_i, rst_i, valid_i, flush_i, ready_i;
    logic [31:0]      instr_i;
    logic [XLEN-1:0]  pc_i;
    logic             ready_o, valid_o, hazard_o, illegal_o;
    logic [XLEN-1:0]  pc_o, imm_o;
    logic             is_pc_o, br_unsigned_o, rd_wren_o, op_a_sel_o, op_b_sel_o;
    logic             mem_wren_o, ls_unsign_o;
    logic [4:0]       alu_op_o, rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [1:0]       wb_sel_o;
    logic [3:0]       sl_op_o;
    logic [CNT_W-1:0] stall_cnt_o;

    decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .valid_o(valid_o),
        .ready_i(ready_i), .pc_o(pc_o), .is_pc_o(is_pc_o), .br_unsigned_o(br_unsigned_o),
        .rd_wren_o(rd_wren_o), .op_a_sel_o(op_a_sel_o), .op_b_sel_o(op_b_sel_o),
        .mem_wren_o(mem_wren_o), .ls_unsign_o(ls_unsign_o), .alu_op_o(alu_op_o),
        .wb_sel_o(wb_sel_o), .sl_op_o(sl_op_o), .imm_o(imm_o), .rs1_addr_o(rs1_addr_o),
        .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o), .illegal_o(illegal_o),
        .hazard_o(hazard_o), .stall_cnt_o(stall_cnt_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // ---------------- scoreboard ----------------
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       mon_en = 1'b0;
    logic [4:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output-order monitor: each transfer out must carry the next expected rd.
    always @(negedge clk_i) begin
        if (mon_en && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                chk("order_extra", {59'b0, rd_addr_o}, 64'hFF);
            end else begin
                chk("order_rd", {59'b0, rd_addr_o}, {59'b0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  flags;   // is_pc, br_unsigned, rd_wren, op_a_sel, op_b_sel, mem_wren, ls_unsign
        logic [4:0]  alu;
        logic [1:0]  wb;
        logic [3:0]  sl;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] I_LW_X2  = 32'h0000A103;  // lw   x2,0(x1)
    localparam logic [31:0] I_ADD_D  = 32'h002101B3;  // add  x3,x2,x2
    localparam logic [31:0] I_ADD_ND = 32'h00108233;  // add  x4,x1,x1
    localparam logic [31:0] I_ADDI_A = 32'h00100513;  // addi x10,x0,1
    localparam logic [31:0] I_ADDI_B = 32'h00200593;  // addi x11,x0,2

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        instr_i = '0;
        pc_i    = '0;

        vecs.push_back('{32'hFFB00093, 7'b0110101, 5'd0, 2'b01, 4'b0000, 32'hFFFFFFFB, 5'd0, 5'd27, 5'd1, 1'b0}); // addi x1,x0,-5
        vecs.push_back('{32'h0000A103, 7'b0110100, 5'd0, 2'b00, 4'b1111, 32'h00000000, 5'd1, 5'd0, 5'd2, 1'b0});  // lw
        vecs.push_back('{32'h002101B3, 7'b0110001, 5'd0, 2'b01, 4'b0000, 32'h00000000, 5'd2, 5'd2, 5'd3, 1'b0});  // add
        vecs.push_back('{32'h40628233, 7'b0110001, 5'd1, 2'b01, 4'b0000, 32'h00000000, 5'd5, 5'd6, 5'd4, 1'b0});  // sub
        vecs.push_back('{32'h40345393, 7'b0110101, 5'd9, 2'b01, 4'b0000, 32'h00000003, 5'd8, 5'd3, 5'd7, 1'b0});  // srai
        vecs.push_back('{32'h0020A423, 7'b0100110, 5'd0, 2'b00, 4'b1111, 32'h00000008, 5'd1, 5'd2, 5'd8, 1'b0});  // sw
        vecs.push_back('{32'hFE20EEE3, 7'b1101101, 5'd0, 2'b00, 4'b0000, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd29, 1'b0}); // bltu
        vecs.push_back('{32'h00000463, 7'b1001101, 5'd0, 2'b00, 4'b0000, 32'h00000008, 5'd0, 5'd0, 5'd8, 1'b0});  // beq
        vecs.push_back('{32'h010000EF, 7'b1111101, 5'd0, 2'b10, 4'b0000, 32'h00000010, 5'd0, 5'd16, 5'd1, 1'b0}); // jal
        vecs.push_back('{32'h123452B7, 7'b0110101, 5'd0, 2'b01, 4'b0000, 32'h12345000, 5'd8, 5'd3, 5'd5, 1'b0});  // lui
        vecs.push_back('{32'hFFE1D483, 7'b0110101, 5'd0, 2'b00, 4'b0011, 32'hFFFFFFFE, 5'd3, 5'd30, 5'd9, 1'b0}); // lhu
`ifdef RV32M_EN
        vecs.push_back('{32'h027302B3, 7'b0110001, 5'd10, 2'b01, 4'b0000, 32'h00000000, 5'd6, 5'd7, 5'd5, 1'b0}); // mul
`else
        vecs.push_back('{32'h027302B3, 7'b0000000, 5'd0, 2'b00, 4'b0000, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b1});  // mul
`endif
        vecs.push_back('{32'h0000007F, 7'b0000000, 5'd0, 2'b00, 4'b0000, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b1});  // bad opcode
        vecs.push_back('{32'hFFF13093, 7'b0110101, 5'd3, 2'b01, 4'b0000, 32'hFFFFFFFF, 5'd2, 5'd31, 5'd1, 1'b0}); // sltiu
        vecs.push_back('{32'h40001033, 7'b0000000, 5'd0, 2'b00, 4'b0000, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b1});  // bad funct7

        // ---- reset state ----
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", {63'b0, valid_o}, 64'd0);
        chk("rst_ready", {63'b0, ready_o}, 64'd1);
        chk("rst_hazard", {63'b0, hazard_o}, 64'd0);
        chk("rst_cnt", {60'b0, stall_cnt_o}, 64'd0);
        chk("rst_fields", {is_pc_o, br_unsigned_o, ls_unsign_o, alu_op_o, imm_o, rd_addr_o},
            64'd0);
        rst_i = 1'b0;
        tick();

        // ---- decode table ----
        for (int i = 0; i < vecs.size(); i++) begin
            instr_i = vecs[i].instr;
            pc_i    = 32'h1000 + 32'(4 * i);
            valid_i = 1'b1;
            ready_i = 1'b1;
            tick();
            valid_i = 1'b0;
            chk($sformatf("v%0d.valid", i), {63'b0, valid_o}, 64'd1);
            chk($sformatf("v%0d.pc", i), {32'b0, pc_o}, {32'b0, 32'h1000 + 32'(4 * i)});
            chk($sformatf("v%0d.flags", i),
                {57'b0, is_pc_o, br_unsigned_o, rd_wren_o, op_a_sel_o, op_b_sel_o, mem_wren_o,
                 ls_unsign_o}, {57'b0, vecs[i].flags});
            chk($sformatf("v%0d.alu_wb_sl", i), {53'b0, alu_op_o, wb_sel_o, sl_op_o},
                {53'b0, vecs[i].alu, vecs[i].wb, vecs[i].sl});
            chk($sformatf("v%0d.imm", i), {32'b0, imm_o}, {32'b0, vecs[i].imm});
            chk($sformatf("v%0d.regs", i), {49'b0, rs1_addr_o, rs2_addr_o, rd_addr_o},
                {49'b0, vecs[i].rs1, vecs[i].rs2, vecs[i].rd});
            chk($sformatf("v%0d.illegal", i), {63'b0, illegal_o}, {63'b0, vecs[i].ill});
            tick();
            chk($sformatf("v%0d.drain", i), {63'b0, valid_o}, 64'd0);
        end
        chk("table_cnt", {60'b0, stall_cnt_o}, 64'd0);

        // ---- load-use: one bubble ----
        instr_i = I_LW_X2;
        valid_i = 1'b1;
        ready_i = 1'b1;
        tick();
        instr_i = I_ADD_D;
        #1;
        chk("lu_hazard", {63'b0, hazard_o}, 64'd1);
        chk("lu_ready", {63'b0, ready_o}, 64'd0);
        chk("lu_held_rd", {59'b0, rd_addr_o}, 64'd2);
        tick();
        chk("lu_bubble", {63'b0, valid_o}, 64'd0);
        chk("lu_hazard_clr", {63'b0, hazard_o}, 64'd0);
        chk("lu_ready_back", {63'b0, ready_o}, 64'd1);
        chk("lu_cnt", {60'b0, stall_cnt_o}, 64'd1);
        tick();
        chk("lu_dep_out", {58'b0, valid_o, rd_addr_o}, {58'b0, 1'b1, 5'd3});
        instr_i = I_LW_X2;
        tick();
        instr_i = I_ADD_ND;
        #1;
        chk("nd_hazard", {63'b0, hazard_o}, 64'd0);
        chk("nd_ready", {63'b0, ready_o}, 64'd1);
        tick();
        valid_i = 1'b0;
        chk("nd_out", {58'b0, valid_o, rd_addr_o}, {58'b0, 1'b1, 5'd4});
        tick();
        chk("nd_cnt", {60'b0, stall_cnt_o}, 64'd1);

        // ---- backpressure: ordering and stability ----
        mon_en  = 1'b1;
        ready_i = 1'b0;
        valid_i = 1'b1;
        instr_i = I_ADDI_A;
        exp_q.push_back(5'd10);
        tick();
        instr_i = I_ADDI_B;
        exp_q.push_back(5'd11);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp%0d.ready", k), {63'b0, ready_o}, 64'd0);
            chk($sformatf("bp%0d.hold", k), {26'b0, valid_o, rd_addr_o, imm_o},
                {26'b0, 1'b1, 5'd10, 32'd1});
        end
        ready_i = 1'b1;
        #1;
        chk("bp_release_ready", {63'b0, ready_o}, 64'd1);
        tick();
        valid_i = 1'b0;
        chk("bp_second", {26'b0, valid_o, rd_addr_o, imm_o}, {26'b0, 1'b1, 5'd11, 32'd2});
        tick();
        chk("bp_empty", {63'b0, valid_o}, 64'd0);
        chk("bp_all_out", 64'(exp_q.size()), 64'd0);
        mon_en = 1'b0;

        // ---- stall counting while blocked, then flush ----
        ready_i = 1'b0;
        valid_i = 1'b1;
        instr_i = I_LW_X2;
        tick();
        instr_i = I_ADD_D;
        repeat (5) tick();
        chk("blk_cnt", {60'b0, stall_cnt_o}, 64'd6);
        chk("blk_hazard", {63'b0, hazard_o}, 64'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("flush_valid", {63'b0, valid_o}, 64'd0);
        chk("flush_cnt", {60'b0, stall_cnt_o}, 64'd6);
        tick();
        chk("flush_dropped", {63'b0, valid_o}, 64'd0);

        // ---- counter saturation ----
        valid_i = 1'b1;
        instr_i = I_LW_X2;
        tick();
        instr_i = I_ADD_D;
        repeat (20) tick();
        chk("sat_cnt", {60'b0, stall_cnt_o}, 64'hF);
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        chk("sat_hold", {60'b0, stall_cnt_o}, 64'hF);

        // ---- asynchronous reset mid-stream ----
        valid_i = 1'b1;
        instr_i = I_ADDI_A;
        pc_i    = 32'h2000;
        tick();
        chk("ar_pre", {63'b0, valid_o}, 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("ar_valid", {63'b0, valid_o}, 64'd0);
        chk("ar_cnt", {60'b0, stall_cnt_o}, 64'd0);
        chk("ar_fields", {27'b0, pc_o[31:0], rd_addr_o}, 64'd0);
        chk("ar_ready", {63'b0, ready_o}, 64'd1);
        valid_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
        chk("ar_none", {63'b0, valid_o}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I instruction-decode stage with a valid/ready handshake on both sides, load-use interlock, flush, illegal-instruction flagging and a saturating stall counter. It sits between the fetch stage and the execute stage. It replaces the purely combinational decode path with a decoder followed by the ID/EX pipeline register, and is parametrised in datapath width and counter width.

## Interface
- XLEN, 32: datapath width; 32 or 64. Immediates and PC are XLEN wide; the instruction set decoded is RV32I (+M).
- CNT_W, 16: width of the stall counter.
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is asynchronous and active-high.
- valid_i  in  1  instr_i/pc_i valid.
- ready_o  out  1  stage accepts input this cycle (combinational).
- instr_i  in  32  instruction word.
- pc_i  in  XLEN  PC of instr_i.
- flush_i  in  1  discard held and incoming instruction.
- valid_o  out  1  output register holds an instruction.
- ready_i  in  1  execute consumes the output this cycle.
- pc_o  out  XLEN  registered PC.
- is_pc_o, br_unsigned_o, rd_wren_o, op_a_sel_o, op_b_sel_o, mem_wren_o, ls_unsign_o  out  1 each  registered controls.
- alu_op_o  out  5  ALU operation.
- wb_sel_o  out  2  write-back select.
- sl_op_o  out  4  load/store byte mask.
- imm_o  out  XLEN  sign-extended immediate.
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  5 each  register addresses.
- illegal_o  out  1  held instruction is illegal.
- hazard_o  out  1  load-use interlock active this cycle (combinational).
- stall_cnt_o  out  CNT_W  count of hazard cycles.

## Operation
- **Encodings**
  - alu_op: ADD 0, SUB 1, SLT 2, SLTU 3, AND 4, OR 5, XOR 6, SLL 7, SRL 8, SRA 9; M ops MUL..REMU 10..17.
  - wb_sel: 00 mem, 01 alu, 10 pc+4.
  - sl_op: byte 0001, half 0011, word 1111.
  - op_a_sel: 1 selects pc. op_b_sel: 1 selects imm.
  - is_pc: 1 for branch, JAL, JALR.
  - br_unsigned: 0 only for BEQ/BNE/BLT/BGE; 1 for everything else.
  - ls_unsign: 1 for LBU/LHU and for non-memory instructions.
- **Immediates**
  - I, S, B and J immediates are sign-extended from instr[31] to XLEN, including SLTIU.
  - U immediate is {instr[31:12],12'b0}, sign-extended to XLEN.
  - Shift immediate is zero-extended instr[24:20].
- **Illegal instructions:** an unknown opcode, funct3, or funct7 (anything other than 0000000, 0100000 for SUB/SRA/SRAI, or 0000001 with M enabled) decodes as all-zero controls (a NOP with rd_wren=0, mem_wren=0) with illegal_o=1. It is still passed downstream with valid_o=1.
- **Load-use hazard:** hazard_o = valid_i && valid_o && held is load (wb_sel=00, rd_wren=1) && rd_addr_o≠0 && ((incoming uses rs1 && rs1==rd_addr_o) || (incoming uses rs2 && rs2==rd_addr_o)).
  - rs1 is not used by LUI, AUIPC, JAL. rs2 is used only by R, S, B.
- **Handshake**
  - ready_o = (!valid_o || ready_i) && !hazard_o.
  - Transfer in: valid_i && ready_o. Transfer out: valid_o && ready_i.
- **Output register update priority**
  1. flush_i: valid_o←0; input not captured.
  2. Transfer in: all outputs ← decode(instr_i), valid_o←1.
  3. Transfer out without transfer in: valid_o←0. Other fields hold, don't-care.
  4. Otherwise hold.
- **Stall counter:** increments on every cycle with hazard_o=1 and flush_i=0; saturates at all-ones.

## Timing
- Reset: every registered output, including valid_o and stall_cnt_o, is 0. ready_o=1 and hazard_o=0 immediately.
- Latency is 1 cycle from transfer in to valid_o.
- Throughput is 1 instruction/cycle with ready_i held at 1.
- A load-use pair costs exactly one bubble:
  - Cycle N: the load leaves, hazard_o=1, ready_o=0.
  - Cycle N+1: valid_o=0, and the dependent instruction is accepted.
- Output is stable while valid_o && !ready_i.
- A flush in the same cycle as valid_i drops the incoming instruction. valid_o=0 next cycle regardless of ready_i.
- Reset asserted mid-stream clears state asynchronously. No instruction survives.

## Configuration
- RV32M_EN defined: OP opcode with funct7=0000001 decodes MUL..REMU to alu_op 10..17, rd_wren=1, wb_sel=01, op_b_sel=0.
- RV32M_EN undefined: those encodings are illegal (illegal_o=1, NOP controls). alu_op values above 9 are never produced.

## Structure
- decode_pkg holds:
  - opcode enum;
  - alu_op enum;
  - wb_sel and sl_op constants;
  - funct3 enums for load, store and branch.
- A combinational sub-module, instr_decode, maps instr_i to the control/immediate bundle plus uses_rs1/uses_rs2/illegal flags.
- decode_stage adds the hazard logic, the handshake, the output register and the counter.

## Test plan
- ADDI x1,x0,-5 (0xFFB00093), ready_i=1 → next cycle valid_o=1, alu_op=0, op_b_sel=1, imm_o=0xFFFFFFFB (XLEN=32), rd=1.
- LW x2,0(x1) followed by ADD x3,x2,x2 → exactly one cycle with hazard_o=1, one bubble, stall_cnt_o=1; a following non-dependent ADD causes no stall.
- ready_i=0 for 3 cycles with valid_i=1 → ready_o=0 and outputs frozen; on release, instructions come out in order with none lost.
- flush_i together with valid_i=1 → valid_o=0 next cycle and the incoming instruction does not appear.
- MUL x5,x6,x7 (0x027302B3) → alu_op=10 with RV32M_EN; illegal_o=1 and rd_wren=0 without it. Opcode 0x7F → illegal_o=1.
- Async rst_i mid-stream → all outputs 0 with no clock edge. Counter preset near max → saturates at 2^CNT_W−1.
